adder_operand_entry: RTL and testbench
======================================

Name: adder_operand_entry

Overview:
Upstream input stage for advance_full_adder_3bit on the EP4CE10 board. Debounces two active-low push keys. A select key cycles which operand is being edited. An increment key steps that operand. The block drives registered a[2:0], b[2:0] and c_in straight into the adder, plus one-hot LEDs that show the field being edited.

Parameters:
CNT_MAX, 999_999, number of consecutive stable synchronized samples needed to accept a key level change (20 ms at 50 MHz); simulation uses 4.

Ports:
sys_clk  input  1  system clock (50 MHz)
sys_rst  input  1  synchronous reset, active-high
key_sel_n  input  1  raw select key, active-low, idles 1
key_inc_n  input  1  raw increment key, active-low, idles 1
a  output  3  operand A to adder
b  output  3  operand B to adder
c_in  output  1  carry-in to adder
sel_led  output  3  one-hot edit field: 001=A, 010=B, 100=C_IN
op_valid  output  1  one-cycle pulse, high the cycle after any operand register changes

Behaviour:
- Reset (sys_rst high at a rising edge):
  - a=0, b=0, c_in=0, sel_led=001, op_valid=0.
  - FSM state = EDIT_A.
  - Synchronizer flops and key_stable set to 1; debounce counters cleared.
  - Reset mid-debounce discards any partial count; reset takes priority over every event in the same cycle.
- Per-key debounce (identical instance for each key):
  - Two-flop synchronizer produces key_sync.
  - cnt clears whenever key_sync == key_stable.
  - Otherwise cnt increments each cycle. When cnt == CNT_MAX-1 and key_sync still differs, key_stable <= key_sync and cnt <= 0.
  - A mismatch shorter than CNT_MAX consecutive cycles produces no event.
- Press event:
  - press = key_stable_d & ~key_stable, where key_stable_d is key_stable delayed one cycle. It is a one-cycle pulse on the accepted 1->0 transition.
  - Release (0->1) produces no event.
- FSM, states EDIT_A -> EDIT_B -> EDIT_CIN -> EDIT_A:
  - Advances only on a sel press.
  - sel_led is registered: 001 in EDIT_A, 010 in EDIT_B, 100 in EDIT_CIN.
- Inc press, registered on the same edge the FSM would move:
  - EDIT_A: a <= a+1, modulo 8 (7 wraps to 0).
  - EDIT_B: b <= b+1, modulo 8.
  - EDIT_CIN: c_in <= ~c_in.
- Simultaneous sel and inc press in the same cycle:
  - The increment applies to the field selected before the advance.
  - The FSM advances in that same edge.
- op_valid:
  - Registered; high for exactly the one cycle following an edge at which a, b or c_in was updated.
  - Never asserted by a sel-only press.
- Latency with CNT_MAX=4, key held low from just before edge 0:
  - key_sync low after edge 2.
  - key_stable falls at edge 6.
  - press high during cycle 6–7.
  - Operand updates at edge 7.
  - op_valid high during cycle 7–8.
  - General case: the operand updates at edge CNT_MAX+3.
- Operands hold their value indefinitely between presses. No other path modifies them.

Test Plan:
- Reset (CNT_MAX=4): assert sys_rst 2 cycles with keys at 1 -> a=0, b=0, c_in=0, sel_led=001, op_valid=0.
- Single inc: hold key_inc_n low 20 cycles -> a=1 exactly at edge 7 after the key falls; op_valid high one cycle; no further change while held; release causes no change.
- Bounce rejection: key_inc_n low 3 cycles, high 2, low 3, then high -> a unchanged, op_valid never asserted.
- Wrap and select: 8 inc presses in EDIT_A -> a returns to 0. Then 1 sel press -> sel_led=010, op_valid stays 0. Then 3 inc presses -> b=3.
- c_in toggle and FSM wrap: from EDIT_B, sel press -> sel_led=100; 2 inc presses -> c_in goes 1 then 0; sel press -> sel_led=001.
- Simultaneous: in EDIT_A with a=5, key_sel_n and key_inc_n fall on the same cycle -> a=6 and sel_led=010 at the same edge; op_valid pulses once. Assert sys_rst mid-debounce of a later press -> outputs return to reset values and no event is produced.

Source files
------------

// File: rtl/adder_operand_entry.sv
// Key-driven operand entry for the 3-bit full adder: debounces two active-low keys,
// steps the selected operand field and drives the registered operands to the adder.
module adder_operand_entry #(
    parameter int CNT_MAX = 999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_sel_n,
    input  logic       key_inc_n,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic       c_in,
    output logic [2:0] sel_led,
    output logic       op_valid
);
    localparam int NUM_KEYS = 2;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
    localparam int KEY_SEL = 0;
    localparam int KEY_INC = 1;

    localparam logic [1:0] EDIT_A   = 2'd0;
    localparam logic [1:0] EDIT_B   = 2'd1;
    localparam logic [1:0] EDIT_CIN = 2'd2;

    logic [NUM_KEYS-1:0]         key_raw;
    logic [NUM_KEYS-1:0]         in_q, in_d;
    logic [NUM_KEYS-1:0]         meta_q, meta_d;
    logic [NUM_KEYS-1:0]         sync_q, sync_d;
    logic [NUM_KEYS-1:0]         stable_q, stable_d;
    logic [NUM_KEYS-1:0]         stable_dly_q, stable_dly_d;
    logic [NUM_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]         press;

    logic [1:0] state_q, state_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic [2:0] sel_led_q, sel_led_d;
    logic       op_valid_q, op_valid_d;

    assign key_raw = {key_inc_n, key_sel_n};

    // Raw pad is registered once, then passes a two-flop synchronizer.
    always_comb begin
        in_d         = key_raw;
        meta_d       = in_q;
        sync_d       = meta_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        cnt_d        = cnt_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (sync_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                stable_d[k] = sync_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    // Only the accepted 1->0 edge is an event; release is ignored.
    assign press = stable_dly_q & ~stable_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        op_valid_d = 1'b0;
        // Increment acts on the field selected before any same-cycle advance.
        if (press[KEY_INC]) begin
            op_valid_d = 1'b1;
            case (state_q)
                EDIT_A:  a_d = a_q + 3'd1;
                EDIT_B:  b_d = b_q + 3'd1;
                default: cin_d = ~cin_q;
            endcase
        end
        if (press[KEY_SEL]) begin
            case (state_q)
                EDIT_A:  state_d = EDIT_B;
                EDIT_B:  state_d = EDIT_CIN;
                default: state_d = EDIT_A;
            endcase
        end
        case (state_d)
            EDIT_A:  sel_led_d = 3'b001;
            EDIT_B:  sel_led_d = 3'b010;
            default: sel_led_d = 3'b100;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            in_q         <= '1;
            meta_q       <= '1;
            sync_q       <= '1;
            stable_q     <= '1;
            stable_dly_q <= '1;
            cnt_q        <= '0;
            state_q      <= EDIT_A;
            a_q          <= 3'd0;
            b_q          <= 3'd0;
            cin_q        <= 1'b0;
            sel_led_q    <= 3'b001;
            op_valid_q   <= 1'b0;
        end else begin
            in_q         <= in_d;
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            sel_led_q    <= sel_led_d;
            op_valid_q   <= op_valid_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign c_in     = cin_q;
    assign sel_led  = sel_led_q;
    assign op_valid = op_valid_q;

endmodule

// File: tb/tb_adder_operand_entry.sv
// Directed bench for adder_operand_entry with a short debounce window.
module tb_adder_operand_entry;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key_sel_n = 1'b1;
    logic       key_inc_n = 1'b1;
    logic [2:0] a, b, sel_led;
    logic       c_in, op_valid;

    int errors = 0;
    int checks = 0;
    int ov_cnt = 0;

    adder_operand_entry #(.CNT_MAX(4)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_sel_n(key_sel_n),
        .key_inc_n(key_inc_n),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sel_led  (sel_led),
        .op_valid (op_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance n edges, sampling 1 ns after each and counting op_valid pulses.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            if (op_valid === 1'b1) ov_cnt++;
        end
    endtask

    task automatic press(input bit sel, input bit inc);
        key_sel_n = ~sel;
        key_inc_n = ~inc;
        tick(12);
        key_sel_n = 1'b1;
        key_inc_n = 1'b1;
        tick(12);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        checks++; if (a !== 3'd0) begin errors++; $display("FAIL reset_a: got %0d expected 0", a); end
        checks++; if (b !== 3'd0) begin errors++; $display("FAIL reset_b: got %0d expected 0", b); end
        checks++; if (c_in !== 1'b0) begin errors++; $display("FAIL reset_cin: got %0b expected 0", c_in); end
        checks++; if (sel_led !== 3'b001) begin errors++; $display("FAIL reset_led: got %b expected 001", sel_led); end
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_opv: got %0b expected 0", op_valid); end
    endtask

    task automatic test_single_inc();
        ov_cnt = 0;
        key_inc_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (k == 6) begin
                checks++; if (a !== 3'd0) begin errors++; $display("FAIL inc_early_e6: got a=%0d expected 0", a); end
                checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL inc_opv_e6: got %0b expected 0", op_valid); end
            end
            if (k == 7) begin
                checks++; if (a !== 3'd1) begin errors++; $display("FAIL inc_e7: got a=%0d expected 1", a); end
                checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL inc_opv_e7: got %0b expected 1", op_valid); end
            end
            if (k == 8) begin
                checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL inc_opv_e8: got %0b expected 0", op_valid); end
            end
        end
        checks++; if (a !== 3'd1) begin errors++; $display("FAIL inc_hold: got a=%0d expected 1", a); end
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL inc_pulses: got %0d expected 1", ov_cnt); end
        ov_cnt = 0;
        key_inc_n = 1'b1;
        tick(20);
        checks++; if (a !== 3'd1) begin errors++; $display("FAIL inc_release: got a=%0d expected 1", a); end
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL inc_release_opv: got %0d expected 0", ov_cnt); end
    endtask

    task automatic test_bounce();
        ov_cnt = 0;
        key_inc_n = 1'b0; tick(3);
        key_inc_n = 1'b1; tick(2);
        key_inc_n = 1'b0; tick(3);
        key_inc_n = 1'b1; tick(15);
        checks++; if (a !== 3'd1) begin errors++; $display("FAIL bounce_a: got %0d expected 1", a); end
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL bounce_opv: got %0d expected 0", ov_cnt); end
    endtask

    task automatic test_wrap_select();
        sys_rst = 1'b1; tick(2); sys_rst = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 7; i++) press(1'b0, 1'b1);
        checks++; if (a !== 3'd7) begin errors++; $display("FAIL wrap_a7: got %0d expected 7", a); end
        press(1'b0, 1'b1);
        checks++; if (a !== 3'd0) begin errors++; $display("FAIL wrap_a0: got %0d expected 0", a); end
        checks++; if (ov_cnt !== 8) begin errors++; $display("FAIL wrap_pulses: got %0d expected 8", ov_cnt); end
        ov_cnt = 0;
        press(1'b1, 1'b0);
        checks++; if (sel_led !== 3'b010) begin errors++; $display("FAIL sel_led_b: got %b expected 010", sel_led); end
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL sel_opv: got %0d expected 0", ov_cnt); end
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
        checks++; if (b !== 3'd3) begin errors++; $display("FAIL b_three: got %0d expected 3", b); end
        checks++; if (a !== 3'd0) begin errors++; $display("FAIL b_a_kept: got %0d expected 0", a); end
    endtask

    task automatic test_cin_toggle();
        press(1'b1, 1'b0);
        checks++; if (sel_led !== 3'b100) begin errors++; $display("FAIL sel_led_c: got %b expected 100", sel_led); end
        press(1'b0, 1'b1);
        checks++; if (c_in !== 1'b1) begin errors++; $display("FAIL cin_one: got %0b expected 1", c_in); end
        press(1'b0, 1'b1);
        checks++; if (c_in !== 1'b0) begin errors++; $display("FAIL cin_zero: got %0b expected 0", c_in); end
        checks++; if (b !== 3'd3) begin errors++; $display("FAIL cin_b_kept: got %0d expected 3", b); end
        press(1'b1, 1'b0);
        checks++; if (sel_led !== 3'b001) begin errors++; $display("FAIL sel_led_wrap: got %b expected 001", sel_led); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        checks++; if (a !== 3'd5) begin errors++; $display("FAIL sim_pre_a: got %0d expected 5", a); end
        ov_cnt = 0;
        key_sel_n = 1'b0;
        key_inc_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (k == 6) begin
                checks++; if (a !== 3'd5 || sel_led !== 3'b001) begin errors++; $display("FAIL sim_e6: got a=%0d led=%b expected a=5 led=001", a, sel_led); end
            end
            if (k == 7) begin
                checks++; if (a !== 3'd6 || sel_led !== 3'b010) begin errors++; $display("FAIL sim_e7: got a=%0d led=%b expected a=6 led=010", a, sel_led); end
                checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL sim_opv: got %0b expected 1", op_valid); end
            end
        end
        key_sel_n = 1'b1;
        key_inc_n = 1'b1;
        tick(12);
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL sim_pulses: got %0d expected 1", ov_cnt); end
        checks++; if (b !== 3'd3) begin errors++; $display("FAIL sim_b_kept: got %0d expected 3", b); end
    endtask

    task automatic test_reset_mid_debounce();
        key_inc_n = 1'b0;
        tick(5);
        sys_rst = 1'b1;
        tick(1);
        key_inc_n = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        checks++; if (a !== 3'd0 || b !== 3'd0 || c_in !== 1'b0) begin errors++; $display("FAIL rst_mid_ops: got a=%0d b=%0d c=%0b expected 0 0 0", a, b, c_in); end
        checks++; if (sel_led !== 3'b001 || op_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_led: got led=%b opv=%0b expected 001 0", sel_led, op_valid); end
        ov_cnt = 0;
        tick(15);
        checks++; if (ov_cnt !== 0 || a !== 3'd0) begin errors++; $display("FAIL rst_mid_event: got pulses=%0d a=%0d expected 0 0", ov_cnt, a); end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_bounce();
        test_wrap_select();
        test_cin_toggle();
        test_simultaneous();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
